// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the decryption datapath.
// Byte 0 of a state is its most significant byte.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [7:0]             aes_byte_t;

    typedef enum logic [1:0] {StIdle, StRun, StDone} isb_state_e;

    function automatic aes_byte_t get_byte(input aes_state_t s, input int unsigned i);
        return s[AES_STATE_W-1-8*i -: 8];
    endfunction

endpackage

// File: rtl/inv_sbox_sync.sv
// 256x8 AES inverse S-box ROM with a registered output (one-cycle read latency).
module inv_sbox_sync
    import aes_pkg::*;
(
    input  logic      clk,
    input  aes_byte_t a,
    output aes_byte_t y
);

    // Row r holds entries 16*r .. 16*r+15; entry 0 sits in the top byte.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    always_ff @(posedge clk) begin
        y <= INV_SBOX_TBL[2047 - 8*int'(a) -: 8];
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: streams the captured state through LANES ROMs,
// LANES bytes per beat, with address issue and writeback overlapped.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic                   busy,
    output logic                   done,
    output logic [AES_STATE_W-1:0] state_out
);

    localparam int unsigned NBEATS = AES_BYTES / LANES;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef logic [BEAT_W-1:0] beat_t;
    localparam beat_t LAST_BEAT = beat_t'(NBEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    isb_state_e st_q, st_d;
    aes_state_t cap_q, cap_d;
    aes_state_t out_q, out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    beat_t      beat_q, beat_d;
    logic       issue_q, issue_d;
    logic       wb_valid_q, wb_valid_d;
    beat_t      wb_beat_q, wb_beat_d;

    aes_byte_t  rom_a [LANES];
    aes_byte_t  rom_y [LANES];

    always_comb begin
        for (int j = 0; j < int'(LANES); j++) begin
            rom_a[j] = get_byte(cap_q, int'(beat_q) * int'(LANES) + j);
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        inv_sbox_sync u_rom (
            .clk (clk),
            .a   (rom_a[g]),
            .y   (rom_y[g])
        );
    end

    always_comb begin
        st_d       = st_q;
        cap_d      = cap_q;
        out_d      = out_q;
        busy_d     = busy_q;
        done_d     = done_q;
        beat_d     = beat_q;
        issue_d    = issue_q;
        wb_valid_d = wb_valid_q;
        wb_beat_d  = wb_beat_q;
        unique case (st_q)
            StIdle, StDone: begin
                if (start) begin
                    cap_d      = state_in;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    beat_d     = '0;
                    issue_d    = 1'b1;
                    wb_valid_d = 1'b0;
                    st_d       = StRun;
                end
            end
            StRun: begin
                // ROM data registered this edge belongs to the beat issued now.
                wb_valid_d = issue_q;
                wb_beat_d  = beat_q;
                if (issue_q) begin
                    if (beat_q == LAST_BEAT) begin
                        issue_d = 1'b0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                if (wb_valid_q) begin
                    for (int j = 0; j < int'(LANES); j++) begin
                        out_d[AES_STATE_W-1 - 8*(int'(wb_beat_q) * int'(LANES) + j) -: 8] =
                            rom_y[j];
                    end
                    if (wb_beat_q == LAST_BEAT) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        st_d   = StDone;
                    end
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q       <= StIdle;
            cap_q      <= '0;
            out_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            beat_q     <= '0;
            issue_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_beat_q  <= '0;
        end else begin
            st_q       <= st_d;
            cap_q      <= cap_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            beat_q     <= beat_d;
            issue_q    <= issue_d;
            wb_valid_q <= wb_valid_d;
            wb_beat_q  <= wb_beat_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = out_q;

endmodule
